// File: rtl/hack_mem_arbiter.sv
// -----------------------------------------------------------------------------
// hack_mem_arbiter
//   Three-port arbiter in front of a single-port synchronous RAM.
//   Ports: cpu (read/write, highest priority), scr (screen refresh, read-only,
//   starvation-protected), host (read/write). One access is issued per cycle.
//
//   Handshake: p_req is a level request held high until accepted. p_gnt is
//   combinational and marks the cycle in which the request is consumed; the
//   requester may change or drop p_req/p_addr/p_wdata from the next cycle.
//   A read returns one cycle after its grant as a single-cycle p_rvalid with
//   p_rdata valid in that same cycle.
//
//   Parameters:
//     WIDTH      data width
//     AW         word address width
//     STARVE_MAX cycles scr may wait before it overrides everyone (1..255)
//
//   Port summary:
//     clk, reset_n                   clock, synchronous active-low reset
//     cpu_req/we/addr/wdata          cpu request      -> cpu_gnt
//     scr_req/addr                   screen request   -> scr_gnt
//     host_req/we/addr/wdata         host request     -> host_gnt
//     p_rvalid, p_rdata              per-port read return
//     mem_en/we/addr/wdata           RAM command (outputs)
//     mem_rdata                      RAM read data, one cycle after read cmd
// -----------------------------------------------------------------------------
module hack_mem_arbiter #(
  parameter int WIDTH      = 16,
  parameter int AW         = 15,
  parameter int STARVE_MAX = 8
) (
  input  logic             clk,
  input  logic             reset_n,

  input  logic             cpu_req,
  input  logic             cpu_we,
  input  logic [AW-1:0]    cpu_addr,
  input  logic [WIDTH-1:0] cpu_wdata,
  output logic             cpu_gnt,
  output logic             cpu_rvalid,
  output logic [WIDTH-1:0] cpu_rdata,

  input  logic             scr_req,
  input  logic [AW-1:0]    scr_addr,
  output logic             scr_gnt,
  output logic             scr_rvalid,
  output logic [WIDTH-1:0] scr_rdata,

  input  logic             host_req,
  input  logic             host_we,
  input  logic [AW-1:0]    host_addr,
  input  logic [WIDTH-1:0] host_wdata,
  output logic             host_gnt,
  output logic             host_rvalid,
  output logic [WIDTH-1:0] host_rdata,

  output logic             mem_en,
  output logic             mem_we,
  output logic [AW-1:0]    mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata
);

  localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

  // Which port the read data arriving this cycle belongs to.
  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_CPU  = 2'd1,
    TAG_SCR  = 2'd2,
    TAG_HOST = 2'd3
  } tag_t;

  logic             rr_host;     // 0: scr wins a scr/host tie, 1: host wins
  logic [7:0]       starve_cnt;  // consecutive cycles scr has waited
  tag_t             tag_q;
  tag_t             tag_d;
  logic             starve_hit;
  logic [WIDTH-1:0] cpu_hold;
  logic [WIDTH-1:0] scr_hold;
  logic [WIDTH-1:0] host_hold;

  assign starve_hit = scr_req && (starve_cnt >= STARVE_LIM);

  // Grant selection. Reset forces every grant low so no RAM access escapes.
  always_comb begin
    cpu_gnt  = 1'b0;
    scr_gnt  = 1'b0;
    host_gnt = 1'b0;
    if (reset_n) begin
      if (starve_hit) begin
        scr_gnt = 1'b1;
      end else if (cpu_req) begin
        cpu_gnt = 1'b1;
      end else if (scr_req && host_req) begin
        if (rr_host) host_gnt = 1'b1;
        else         scr_gnt  = 1'b1;
      end else if (scr_req) begin
        scr_gnt = 1'b1;
      end else if (host_req) begin
        host_gnt = 1'b1;
      end
    end
  end

  // RAM command mux and the tag for the read issued this cycle.
  always_comb begin
    mem_en    = cpu_gnt | scr_gnt | host_gnt;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    tag_d     = TAG_NONE;
    if (cpu_gnt) begin
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      tag_d     = cpu_we ? TAG_NONE : TAG_CPU;
    end else if (scr_gnt) begin
      mem_addr  = scr_addr;
      tag_d     = TAG_SCR;
    end else if (host_gnt) begin
      mem_we    = host_we;
      mem_addr  = host_addr;
      mem_wdata = host_wdata;
      tag_d     = host_we ? TAG_NONE : TAG_HOST;
    end
  end

  // Arbiter state. Clearing the tag on reset discards any read that was
  // granted just before reset, so it never shows up as rvalid afterwards.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rr_host    <= 1'b0;
      starve_cnt <= 8'd0;
      tag_q      <= TAG_NONE;
      cpu_hold   <= '0;
      scr_hold   <= '0;
      host_hold  <= '0;
    end else begin
      if (scr_gnt)       rr_host <= 1'b1;
      else if (host_gnt) rr_host <= 1'b0;

      if (scr_gnt || !scr_req)    starve_cnt <= 8'd0;
      else if (starve_cnt != 8'hFF) starve_cnt <= starve_cnt + 8'd1;

      tag_q <= tag_d;

      // Capture returning data so each port keeps its last read value.
      if (tag_q == TAG_CPU)  cpu_hold  <= mem_rdata;
      if (tag_q == TAG_SCR)  scr_hold  <= mem_rdata;
      if (tag_q == TAG_HOST) host_hold <= mem_rdata;
    end
  end

  // Returning data is passed straight through in its arrival cycle.
  assign cpu_rvalid  = (tag_q == TAG_CPU);
  assign scr_rvalid  = (tag_q == TAG_SCR);
  assign host_rvalid = (tag_q == TAG_HOST);
  assign cpu_rdata   = cpu_rvalid  ? mem_rdata : cpu_hold;
  assign scr_rdata   = scr_rvalid  ? mem_rdata : scr_hold;
  assign host_rdata  = host_rvalid ? mem_rdata : host_hold;

endmodule
